// File: rtl/ucca_pkg.sv
// Shared definitions for the UCC access monitor: region FSM state encoding,
// region count, reset program counter and the inclusive range helpers.
package ucca_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_INSIDE = 2'd1,
        ST_KILL   = 2'd2
    } ucca_state_e;

    localparam int          NUM_UCC  = 3;
    localparam logic [15:0] RESET_PC = 16'h0000;

    // A region whose lower bound exceeds its upper bound is disabled.
    function automatic logic region_valid(
        input logic [15:0] lo,
        input logic [15:0] hi
    );
        return (lo <= hi);
    endfunction

    function automatic logic addr_in_region(
        input logic [15:0] addr,
        input logic [15:0] lo,
        input logic [15:0] hi
    );
        return region_valid(lo, hi) && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/ucca_region_fsm.sv
// One UCC region watchdog: tracks legal entry/exit of a code region and traps
// illegal control flow. DMA write trapping is built only with UCCA_DMA_CHECK_EN.
module ucca_region_fsm
    import ucca_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_pc_prev,
    input  logic [15:0] i_ucc_min,
    input  logic [15:0] i_ucc_max,
    input  logic        i_irq,
    input  logic        i_dma_en,
    input  logic [15:0] i_dma_addr,
    output logic        o_in_ucc,
    output logic        o_viol,
    output logic        o_kill_nxt
);

    ucca_state_e r_state;
    ucca_state_e w_state_nxt;
    logic        r_in_ucc;
    logic        r_viol;
    logic        w_valid;
    logic        w_pc_in;
    logic        w_prev_in;
    logic        w_dma_hit;

    assign w_valid   = region_valid(i_ucc_min, i_ucc_max);
    assign w_pc_in   = addr_in_region(i_pc, i_ucc_min, i_ucc_max);
    assign w_prev_in = addr_in_region(i_pc_prev, i_ucc_min, i_ucc_max);

`ifdef UCCA_DMA_CHECK_EN
    assign w_dma_hit = i_dma_en && addr_in_region(i_dma_addr, i_ucc_min, i_ucc_max);
`else
    logic w_unused_dma;
    assign w_unused_dma = i_dma_en ^ (^i_dma_addr);
    assign w_dma_hit    = 1'b0;
`endif

    // Next-state decode; every trap condition is tested before any legal move.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_dma_hit) begin
                    w_state_nxt = ST_KILL;
                end else if (!w_prev_in && w_pc_in) begin
                    w_state_nxt = (i_pc == i_ucc_min) ? ST_INSIDE : ST_KILL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_INSIDE: begin
                // A region disabled while executing in it is silently dropped.
                if (!w_valid) begin
                    w_state_nxt = ST_RUN;
                end else if (w_dma_hit || i_irq) begin
                    w_state_nxt = ST_KILL;
                end else if (!w_pc_in) begin
                    w_state_nxt = (i_pc_prev == i_ucc_max) ? ST_RUN : ST_KILL;
                end else begin
                    w_state_nxt = ST_INSIDE;
                end
            end
            ST_KILL: begin
                if (i_pc == RESET_PC) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_KILL;
                end
            end
            default: begin
                w_state_nxt = ST_KILL;
            end
        endcase
    end

    // State register plus outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_in_ucc <= 1'b0;
            r_viol   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_in_ucc <= (w_state_nxt == ST_INSIDE);
            r_viol   <= (w_state_nxt == ST_KILL) && (r_state != ST_KILL);
        end
    end

    assign o_in_ucc   = r_in_ucc;
    assign o_viol     = r_viol;
    assign o_kill_nxt = (w_state_nxt == ST_KILL);

endmodule

// File: rtl/ucca_monitor.sv
// UCC access monitor top: previous-PC register, NUM_UCC region FSMs and the
// registered MCU reset request. Optional DMA trapping: UCCA_DMA_CHECK_EN.
module ucca_monitor
    import ucca_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        irq,
    input  logic        dma_en,
    input  logic [15:0] dma_addr,
    input  logic [15:0] ucc_min_0,
    input  logic [15:0] ucc_max_0,
    input  logic [15:0] ucc_min_1,
    input  logic [15:0] ucc_max_1,
    input  logic [15:0] ucc_min_2,
    input  logic [15:0] ucc_max_2,
    output logic        ucca_reset,
    output logic [2:0]  in_ucc,
    output logic [2:0]  viol
);

    logic [15:0]        r_pc_prev;
    logic               r_ucca_reset;
    logic [15:0]        w_min [NUM_UCC];
    logic [15:0]        w_max [NUM_UCC];
    logic [NUM_UCC-1:0] w_in_ucc;
    logic [NUM_UCC-1:0] w_viol;
    logic [NUM_UCC-1:0] w_kill_nxt;

    assign w_min[0] = ucc_min_0;
    assign w_max[0] = ucc_max_0;
    assign w_min[1] = ucc_min_1;
    assign w_max[1] = ucc_max_1;
    assign w_min[2] = ucc_min_2;
    assign w_max[2] = ucc_max_2;

    for (genvar g = 0; g < NUM_UCC; g++) begin : g_region
        ucca_region_fsm u_fsm (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_pc       (pc),
            .i_pc_prev  (r_pc_prev),
            .i_ucc_min  (w_min[g]),
            .i_ucc_max  (w_max[g]),
            .i_irq      (irq),
            .i_dma_en   (dma_en),
            .i_dma_addr (dma_addr),
            .o_in_ucc   (w_in_ucc[g]),
            .o_viol     (w_viol[g]),
            .o_kill_nxt (w_kill_nxt[g])
        );
    end

    // Previous PC and the reset request, which rises together with viol.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_prev    <= RESET_PC;
            r_ucca_reset <= 1'b0;
        end else begin
            r_pc_prev    <= pc;
            r_ucca_reset <= |w_kill_nxt;
        end
    end

    assign ucca_reset = r_ucca_reset;
    assign in_ucc     = w_in_ucc;
    assign viol       = w_viol;

endmodule

// File: tb/tb_ucca_monitor.sv
// Directed scoreboard bench for ucca_monitor; expected {ucca_reset,in_ucc,viol}
// per cycle are queued with the stimulus and checked one cycle later.
module tb_ucca_monitor;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        irq;
    logic        dma_en;
    logic [15:0] dma_addr;
    logic [15:0] ucc_min_0, ucc_max_0;
    logic [15:0] ucc_min_1, ucc_max_1;
    logic [15:0] ucc_min_2, ucc_max_2;
    logic        ucca_reset;
    logic [2:0]  in_ucc;
    logic [2:0]  viol;

    typedef struct {
        logic [6:0] exp;
        string      tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_vec  = 0;
    int        n_miss = 0;

`ifdef UCCA_DMA_CHECK_EN
    localparam logic [6:0] EXP_DMA = 7'b1_000_010;
`else
    localparam logic [6:0] EXP_DMA = 7'b0_000_000;
`endif

    ucca_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .irq        (irq),
        .dma_en     (dma_en),
        .dma_addr   (dma_addr),
        .ucc_min_0  (ucc_min_0),
        .ucc_max_0  (ucc_max_0),
        .ucc_min_1  (ucc_min_1),
        .ucc_max_1  (ucc_max_1),
        .ucc_min_2  (ucc_min_2),
        .ucc_max_2  (ucc_max_2),
        .ucca_reset (ucca_reset),
        .in_ucc     (in_ucc),
        .viol       (viol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [15:0] p, input logic q,
                        input logic de, input logic [15:0] da,
                        input logic [6:0] exp, input string tag);
        sb_entry_t e;
        logic [6:0] obs;
        rst_n    = r;
        pc       = p;
        irq      = q;
        dma_en   = de;
        dma_addr = da;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        obs = {ucca_reset, in_ucc, viol};
        n_vec++;
        assert (obs === e.exp) else begin
            n_miss++;
            $error("FAIL %s: observed rst/in/viol=%b expected %b", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        ucc_min_0 = 16'hE000; ucc_max_0 = 16'hE0FF;
        ucc_min_1 = 16'hE100; ucc_max_1 = 16'hE1FF;
        ucc_min_2 = 16'hFF00; ucc_max_2 = 16'hFE00;
        rst_n = 1'b0; pc = 16'h4000; irq = 1'b0; dma_en = 1'b0; dma_addr = 16'h0000;

        // reset state
        step(1'b0, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "reset");
        // legal entry, walk, legal exit
        step(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "idle");
        step(1'b1, 16'hE000, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "enter_min");
        step(1'b1, 16'hE010, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "inside_mid");
        step(1'b1, 16'hE0FF, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "inside_max");
        step(1'b1, 16'h4002, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "legal_exit");
        // illegal entry, KILL held until RESET_PC
        step(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "pre_bad_entry");
        step(1'b1, 16'hE010, 1'b0, 1'b0, 16'h0000, 7'b1_000_001, "bad_entry");
        step(1'b1, 16'hE020, 1'b0, 1'b0, 16'h0000, 7'b1_000_000, "kill_hold1");
        step(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 7'b1_000_000, "kill_hold2");
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "kill_release");
        step(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "after_release");
        // illegal exit
        step(1'b1, 16'hE000, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "enter2");
        step(1'b1, 16'hE020, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "inside2");
        step(1'b1, 16'h4002, 1'b0, 1'b0, 16'h0000, 7'b1_000_001, "bad_exit");
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "release2");
        // interrupt inside and outside a region
        step(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "pre_irq");
        step(1'b1, 16'hE000, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "enter3");
        step(1'b1, 16'hE050, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "inside3");
        step(1'b1, 16'hE050, 1'b1, 1'b0, 16'h0000, 7'b1_000_001, "irq_inside");
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "release3");
        step(1'b1, 16'h4000, 1'b1, 1'b0, 16'h0000, 7'b0_000_000, "irq_outside");
        // adjacent regions: leave r1 at its max straight into r0 at its min
        step(1'b1, 16'hE100, 1'b0, 1'b0, 16'h0000, 7'b0_010_000, "enter_r1");
        step(1'b1, 16'hE1FF, 1'b0, 1'b0, 16'h0000, 7'b0_010_000, "r1_max");
        step(1'b1, 16'hE000, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "r1_to_r0");
        step(1'b1, 16'hE0FF, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "r0_max");
        step(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "exit_r0");
        // overlapping regions violate together; bounds take effect at once
        ucc_min_1 = 16'hE000; ucc_max_1 = 16'hE0FF;
        step(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "overlap_idle");
        step(1'b1, 16'hE010, 1'b0, 1'b0, 16'h0000, 7'b1_000_011, "overlap_kill");
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "overlap_release");
        ucc_min_1 = 16'hE100; ucc_max_1 = 16'hE1FF;
        // DMA write into r1, then invalid region r2
        step(1'b1, 16'h4000, 1'b0, 1'b1, 16'hE180, EXP_DMA, "dma_r1");
        step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "dma_release");
        step(1'b1, 16'hFE80, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "invalid_r2_pc");
        step(1'b1, 16'hFE00, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "invalid_r2_max");
        step(1'b1, 16'h4000, 1'b0, 1'b1, 16'hFE80, 7'b0_000_000, "invalid_r2_dma");
        // reset while in KILL and while inside a region
        step(1'b1, 16'hE010, 1'b0, 1'b0, 16'h0000, 7'b1_000_001, "kill_again");
        step(1'b1, 16'hE020, 1'b0, 1'b0, 16'h0000, 7'b1_000_000, "kill_again_hold");
        step(1'b0, 16'hE020, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "reset_in_kill");
        step(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "after_reset_kill");
        step(1'b1, 16'hE000, 1'b0, 1'b0, 16'h0000, 7'b0_001_000, "enter4");
        step(1'b0, 16'hE010, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "reset_inside");
        step(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000, 7'b0_000_000, "after_reset_inside");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ucca_monitor.md
UCCA_MONITOR -- requirements
Module: ucca_monitor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port pc, input, 16 bits: current program counter.
REQ-004 SHALL have port irq, input, 1 bit: interrupt being taken this cycle.
REQ-005 SHALL have port dma_en, input, 1 bit: DMA write strobe.
REQ-006 SHALL have port dma_addr, input, 16 bits: DMA write address.
REQ-007 SHALL have ports ucc_min_0/ucc_max_0, ucc_min_1/ucc_max_1 and ucc_min_2/ucc_max_2, each input, 16 bits: inclusive UCC region bounds from the CR peripheral.
REQ-008 SHALL have port ucca_reset, output, 1 bit: MCU reset request.
REQ-009 SHALL have port in_ucc, output, 3 bits: bit i set while execution is inside region i.
REQ-010 SHALL have port viol, output, 3 bits: bit i is a one-cycle pulse when region i is violated.

Function
REQ-011 SHALL treat region i as valid only when ucc_min_i <= ucc_max_i (unsigned); an invalid region never matches and never flags.
REQ-012 SHALL register pc into pc_prev every cycle; in-region tests are inclusive on both bounds.
REQ-013 SHALL run one FSM per region with states RUN, INSIDE and KILL.
REQ-014 RUN -> INSIDE SHALL occur when pc_prev is outside, pc is inside and pc == ucc_min_i (legal entry).
REQ-015 RUN -> KILL SHALL occur when pc_prev is outside, pc is inside and pc != ucc_min_i (illegal entry).
REQ-016 INSIDE -> RUN SHALL occur when pc is outside and pc_prev == ucc_max_i (legal exit).
REQ-017 INSIDE -> KILL SHALL occur when pc is outside and pc_prev != ucc_max_i (illegal exit).
REQ-018 INSIDE -> KILL SHALL occur when irq=1 while in INSIDE.
REQ-019 Any state except KILL SHALL go to KILL on dma_en=1 with dma_addr inside a valid region i (only when UCCA_DMA_CHECK_EN is defined).
REQ-020 KILL -> RUN SHALL occur only when pc == RESET_PC; otherwise the FSM stays in KILL.
REQ-021 When the KILL condition and a legal transition coincide, KILL SHALL win.
REQ-022 ucca_reset SHALL be registered and equal 1 in the cycle after any FSM enters KILL, and SHALL stay 1 while any FSM is in KILL (OR across regions).
REQ-023 viol[i] SHALL pulse for exactly one cycle, aligned with the first ucca_reset cycle caused by region i.
REQ-024 in_ucc[i] SHALL be 1 exactly while FSM i is in INSIDE.
REQ-025 Region FSMs SHALL be independent: overlapping regions are each evaluated, and simultaneous violations set multiple viol bits.
REQ-026 Bound changes SHALL take effect on the next comparison, with no latching of bounds.

Reset
REQ-027 With rst_n=0 at a clock edge: all FSMs go to RUN, pc_prev = RESET_PC, ucca_reset=0, in_ucc=0, viol=0.
REQ-028 A reset mid-region or mid-KILL SHALL abandon that state unconditionally.

Configuration
REQ-029 SHALL use macro UCCA_DMA_CHECK_EN. Defined: REQ-019 is active. Undefined: dma_en and dma_addr are ignored, the ports remain and no DMA logic is generated.

Structure
REQ-030 SHALL place the following in shared package ucca_pkg:
- state encoding (RUN=2'd0, INSIDE=2'd1, KILL=2'd2)
- NUM_UCC=3
- RESET_PC=16'h0000
REQ-031 SHALL implement one FSM in sub-module ucca_region_fsm, instantiated NUM_UCC times; the top holds pc_prev and the ucca_reset OR.

Verification
Regions: r0 = E000-E0FF, r1 = E100-E1FF, r2 = FF00..FE00 (invalid).
REQ-032 pc 4000 -> E000 -> E010 -> E0FF -> 4002: in_ucc[0] high E000..E0FF, ucca_reset stays 0.
REQ-033 pc 4000 -> E010: viol=3'b001 one cycle later, ucca_reset=1 until pc=0000, then 0 on the next cycle.
REQ-034 pc E000 -> E020 -> 4002: illegal exit, so viol[0] pulses and ucca_reset asserts.
REQ-035 pc at E050 inside r0 with irq=1: KILL on region 0; same irq with pc=4000 produces no violation.
REQ-036 dma_en=1, dma_addr=E180: with the macro, viol=3'b010 and reset; without it, no response. Also pc=FE80 produces no response (invalid r2).
REQ-037 rst_n=0 while in KILL: ucca_reset=0 on the next cycle and all FSMs go to RUN.
